// File: rtl/timer_irq_pkg.sv
// Shared definitions for the machine timer peripheral: bus widths, interrupt
// codes, register offsets and CTRL bit positions.
package timer_irq_pkg;

  localparam int REG_W  = 32;
  localparam int ADDR_W = 32;
  localparam int INT_W  = 8;

  typedef logic [REG_W-1:0]  reg_bus_t;
  typedef logic [ADDR_W-1:0] mem_addr_bus_t;
  typedef logic [INT_W-1:0]  int_bus_t;

  localparam int_bus_t INT_NONE   = 8'h00;
  localparam int_bus_t INT_TIMER0 = 8'h01;

  typedef enum logic [1:0] {
    TIMER_CTRL  = 2'd0,
    TIMER_COUNT = 2'd1,
    TIMER_CMP   = 2'd2,
    TIMER_PRESC = 2'd3
  } timer_reg_e;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_IE   = 1;
  localparam int CTRL_PEND = 2;
  localparam int CTRL_AR   = 3;

  // Only the word index selects a register; byte offset and upper bits are ignored.
  function automatic timer_reg_e reg_sel(input mem_addr_bus_t addr);
    return timer_reg_e'(addr[3:2]);
  endfunction

endpackage

// File: rtl/timer_irq_prescaler.sv
// Clock divider for the timer: emits a single-cycle tick every div+1 clocks
// while enabled, and is held at zero when disabled or cleared.
module timer_prescaler
  import timer_irq_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     en,
  input  logic     clr,
  input  reg_bus_t div,
  output logic     tick
);

  reg_bus_t cnt;

  assign tick = en && (cnt == div);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!en || clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + reg_bus_t'(1);
    end
  end

endmodule

// File: rtl/timer_irq.sv
// Memory-mapped machine timer: prescaled 32-bit up-counter with compare,
// one-shot/auto-reload modes and a sticky write-1-to-clear pending interrupt.
module timer_irq
  import timer_irq_pkg::*;
#(
  parameter reg_bus_t PRESC_RST = '0,
  parameter int_bus_t INT_CODE  = INT_TIMER0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_i,
  input  logic          we_i,
  input  mem_addr_bus_t addr_i,
  input  reg_bus_t      data_i,
  output reg_bus_t      data_o,
  output logic          ack_o,
  output int_bus_t      int_sig_o
);

  logic       en, ie, pend, ar;
  reg_bus_t   count, cmp, presc;
  reg_bus_t   ctrl_rd, rd_data;
  timer_reg_e sel;
  logic       wr, rd, tick, hit, presc_clr;

  assign sel = reg_sel(addr_i);
  assign wr  = req_i && we_i;
  assign rd  = req_i && !we_i;
  assign hit = tick && (count == cmp);

  // Restart the divider phase when it is reprogrammed or the timer is newly enabled.
  assign presc_clr = wr && ((sel == TIMER_PRESC) ||
                            ((sel == TIMER_CTRL) && data_i[CTRL_EN] && !en));

  timer_prescaler u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (presc_clr),
    .div  (presc),
    .tick (tick)
  );

  always_comb begin
    ctrl_rd            = '0;
    ctrl_rd[CTRL_EN]   = en;
    ctrl_rd[CTRL_IE]   = ie;
    ctrl_rd[CTRL_PEND] = pend;
    ctrl_rd[CTRL_AR]   = ar;
  end

  always_comb begin
    rd_data = '0;
    case (sel)
      TIMER_CTRL:  rd_data = ctrl_rd;
      TIMER_COUNT: rd_data = count;
      TIMER_CMP:   rd_data = cmp;
      TIMER_PRESC: rd_data = presc;
      default:     rd_data = '0;
    endcase
  end

  // A hardware match beats a same-cycle W1C; a CTRL write beats the one-shot stop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en   <= 1'b0;
      ie   <= 1'b0;
      pend <= 1'b0;
      ar   <= 1'b0;
    end else begin
      if (hit) begin
        pend <= 1'b1;
      end else if (wr && (sel == TIMER_CTRL) && data_i[CTRL_PEND]) begin
        pend <= 1'b0;
      end
      if (wr && (sel == TIMER_CTRL)) begin
        en <= data_i[CTRL_EN];
        ie <= data_i[CTRL_IE];
        ar <= data_i[CTRL_AR];
      end else if (hit && !ar) begin
        en <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      cmp   <= '1;
      presc <= PRESC_RST;
    end else begin
      if (wr && (sel == TIMER_COUNT)) begin
        count <= data_i;
      end else if (tick) begin
        if (!hit) begin
          count <= count + reg_bus_t'(1);
        end else if (ar) begin
          count <= '0;
        end
      end
      if (wr && (sel == TIMER_CMP)) begin
        cmp <= data_i;
      end
      if (wr && (sel == TIMER_PRESC)) begin
        presc <= data_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_o    <= '0;
      ack_o     <= 1'b0;
      int_sig_o <= INT_NONE;
    end else begin
      ack_o     <= req_i;
      int_sig_o <= (pend && ie) ? INT_CODE : INT_NONE;
      if (rd) begin
        data_o <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_timer_irq.sv
// Self-checking bench for timer_irq: table-driven register access, directed
// timing sequences and a randomized run against a behavioural model.
module tb_timer_irq;

  localparam logic [31:0] TB_PRESC_RST = 32'd7;
  localparam logic [7:0]  TB_INT_CODE  = 8'h01;

  localparam logic [31:0] A_CTRL  = 32'h0000_0000;
  localparam logic [31:0] A_COUNT = 32'h0000_0004;
  localparam logic [31:0] A_CMP   = 32'h0000_0008;
  localparam logic [31:0] A_PRESC = 32'h0000_000C;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        req   = 1'b0;
  logic        we    = 1'b0;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ack;
  logic [7:0]  int_sig;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model state
  logic        m_en, m_ie, m_pend, m_ar, m_ack;
  logic [31:0] m_count, m_cmp, m_presc, m_data;
  int unsigned m_phase;
  logic [7:0]  m_int;

  timer_irq #(
    .PRESC_RST (TB_PRESC_RST),
    .INT_CODE  (TB_INT_CODE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req),
    .we_i      (we),
    .addr_i    (addr),
    .data_i    (wdata),
    .data_o    (rdata),
    .ack_o     (ack),
    .int_sig_o (int_sig)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) nextCycle();
  endtask

  // One bus access issued at a falling edge; returns data_o one cycle later.
  task automatic applyStimulus(input logic w, input logic [31:0] a,
                               input logic [31:0] d, output logic [31:0] rd);
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    nextCycle();
    req = 1'b0;
    we  = 1'b0;
    rd  = rdata;
    checkOutput("ack", {31'b0, ack}, 32'd1);
  endtask

  task automatic writeReg(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] held;
    applyStimulus(1'b1, a, d, held);
  endtask

  task automatic readCheck(input string name, input logic [31:0] a,
                           input logic [31:0] exp);
    logic [31:0] v;
    applyStimulus(1'b0, a, 32'h0, v);
    checkOutput(name, v, exp);
  endtask

  task automatic doReset();
    req   = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    rst   = 1'b0;
    idle(2);
    rst = 1'b1;
  endtask

  task automatic modelReset();
    m_en    = 1'b0;
    m_ie    = 1'b0;
    m_pend  = 1'b0;
    m_ar    = 1'b0;
    m_count = 32'h0;
    m_cmp   = 32'hFFFF_FFFF;
    m_presc = TB_PRESC_RST;
    m_phase = 0;
    m_data  = 32'h0;
    m_ack   = 1'b0;
    m_int   = 8'h00;
  endtask

  // Advances the model by one clock given the inputs sampled at that edge.
  task automatic modelStep(input logic r_req, input logic r_we,
                           input logic [31:0] r_addr, input logic [31:0] r_d);
    logic [1:0]  sel;
    logic        wr, tick, hit, clr;
    logic        n_en, n_ie, n_pend, n_ar;
    logic [31:0] n_count, n_cmp, n_presc;
    sel  = r_addr[3:2];
    wr   = r_req && r_we;
    tick = m_en && (m_phase == m_presc);
    hit  = tick && (m_count == m_cmp);

    if (r_req && !r_we) begin
      case (sel)
        2'd0:    m_data = {28'b0, m_ar, m_pend, m_ie, m_en};
        2'd1:    m_data = m_count;
        2'd2:    m_data = m_cmp;
        default: m_data = m_presc;
      endcase
    end
    m_ack = r_req;
    m_int = (m_pend && m_ie) ? TB_INT_CODE : 8'h00;

    n_en = m_en; n_ie = m_ie; n_pend = m_pend; n_ar = m_ar;
    n_count = m_count; n_cmp = m_cmp; n_presc = m_presc;
    if (tick) begin
      if (hit) begin
        n_pend = 1'b1;
        if (m_ar) n_count = 32'h0;
        else      n_en = 1'b0;
      end else begin
        n_count = m_count + 32'd1;
      end
    end
    if (wr) begin
      case (sel)
        2'd0: begin
          n_en = r_d[0];
          n_ie = r_d[1];
          n_ar = r_d[3];
          if (r_d[2] && !hit) n_pend = 1'b0;
        end
        2'd1:    n_count = r_d;
        2'd2:    n_cmp   = r_d;
        default: n_presc = r_d;
      endcase
    end

    clr = wr && ((sel == 2'd3) || ((sel == 2'd0) && r_d[0] && !m_en));
    if (clr || !n_en)             m_phase = 0;
    else if (m_phase == m_presc)  m_phase = 0;
    else                          m_phase = m_phase + 1;

    m_en = n_en; m_ie = n_ie; m_pend = n_pend; m_ar = n_ar;
    m_count = n_count; m_cmp = n_cmp; m_presc = n_presc;
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] r;
    logic [1:0]  sel;

    doReset();
    checkOutput("rst_ack",  {31'b0, ack}, 32'd0);
    checkOutput("rst_data", rdata, 32'd0);
    checkOutput("rst_int",  {24'b0, int_sig}, 32'd0);

    // Reset values, address aliasing, data_o hold on writes, CTRL masking
    vecs.push_back('{1'b0, A_CTRL,        32'h0,         1'b1, 32'h0});
    vecs.push_back('{1'b0, A_COUNT,       32'h0,         1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_0009, 32'h0,         1'b1, 32'hFFFF_FFFF});
    vecs.push_back('{1'b0, 32'hF000_000C, 32'h0,         1'b1, TB_PRESC_RST});
    vecs.push_back('{1'b1, A_CMP,         32'h1234_5678, 1'b1, TB_PRESC_RST});
    vecs.push_back('{1'b0, 32'h0000_000A, 32'h0,         1'b1, 32'h1234_5678});
    vecs.push_back('{1'b1, A_PRESC,       32'h55,        1'b0, 32'h0});
    vecs.push_back('{1'b0, A_PRESC,       32'h0,         1'b1, 32'h55});
    vecs.push_back('{1'b1, 32'h0000_0007, 32'hDEAD_BEEF, 1'b0, 32'h0});
    vecs.push_back('{1'b0, A_COUNT,       32'h0,         1'b1, 32'hDEAD_BEEF});
    vecs.push_back('{1'b1, A_CTRL,        32'hFFFF_FFFA, 1'b0, 32'h0});
    vecs.push_back('{1'b0, A_CTRL,        32'h0,         1'b1, 32'hA});
    vecs.push_back('{1'b1, A_CTRL,        32'h0,         1'b0, 32'h0});
    vecs.push_back('{1'b0, A_CTRL,        32'h0,         1'b1, 32'h0});
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, v);
      if (vecs[i].chk) checkOutput($sformatf("vec%0d", i), v, vecs[i].exp);
    end
    checkOutput("tbl_int", {24'b0, int_sig}, 32'd0);

    // Auto-reload: COUNT 0..5, match on the 6th tick, repeat every 6 clocks
    writeReg(A_PRESC, 32'd0);
    writeReg(A_CMP, 32'd5);
    writeReg(A_COUNT, 32'd0);
    writeReg(A_CTRL, 32'hB);
    for (int i = 0; i < 6; i++) readCheck($sformatf("ar_count%0d", i), A_COUNT, i);
    checkOutput("ar_int_before", {24'b0, int_sig}, 32'd0);
    readCheck("ar_ctrl_pend", A_CTRL, 32'hF);
    checkOutput("ar_int_set", {24'b0, int_sig}, 32'h01);
    readCheck("ar_count_wrap", A_COUNT, 32'd1);
    idle(4);
    readCheck("ar_repeat0", A_COUNT, 32'd0);
    readCheck("ar_repeat1", A_COUNT, 32'd1);

    // W1C off a match tick clears; W1C on a match tick loses to the set
    writeReg(A_CTRL, 32'h4);
    writeReg(A_CMP, 32'd3);
    writeReg(A_COUNT, 32'd0);
    writeReg(A_CTRL, 32'hB);
    idle(4);
    checkOutput("w1c_int_pre", {24'b0, int_sig}, 32'd0);
    writeReg(A_CTRL, 32'hF);
    checkOutput("w1c_int_hold", {24'b0, int_sig}, 32'h01);
    idle(1);
    checkOutput("w1c_int_drop", {24'b0, int_sig}, 32'd0);
    readCheck("w1c_ctrl_clr", A_CTRL, 32'hB);
    writeReg(A_CTRL, 32'hF);
    readCheck("w1c_ctrl_race", A_CTRL, 32'hF);
    checkOutput("w1c_int_race", {24'b0, int_sig}, 32'h01);
    readCheck("w1c_count", A_COUNT, 32'd1);

    // One-shot with PRESC=3: ticks every 4 clocks, stop at the match
    writeReg(A_CTRL, 32'h4);
    writeReg(A_PRESC, 32'd3);
    writeReg(A_CMP, 32'd2);
    writeReg(A_COUNT, 32'd0);
    writeReg(A_CTRL, 32'h3);
    idle(3);
    readCheck("os_count0", A_COUNT, 32'd0);
    readCheck("os_count1", A_COUNT, 32'd1);
    idle(6);
    readCheck("os_count2", A_COUNT, 32'd2);
    checkOutput("os_int_before", {24'b0, int_sig}, 32'd0);
    readCheck("os_ctrl", A_CTRL, 32'h6);
    checkOutput("os_int_set", {24'b0, int_sig}, 32'h01);
    idle(8);
    readCheck("os_count_hold", A_COUNT, 32'd2);
    readCheck("os_ctrl_hold", A_CTRL, 32'h6);

    // COUNT write on a tick cycle wins over the increment
    writeReg(A_CTRL, 32'h4);
    writeReg(A_PRESC, 32'd0);
    writeReg(A_CMP, 32'h0000_FFFF);
    writeReg(A_COUNT, 32'd0);
    writeReg(A_CTRL, 32'h1);
    writeReg(A_COUNT, 32'h100);
    readCheck("wr_tick_count", A_COUNT, 32'h100);

    // Wrap from all-ones to zero without PEND, then match on the next tick
    writeReg(A_CTRL, 32'h4);
    writeReg(A_CMP, 32'd0);
    writeReg(A_COUNT, 32'hFFFF_FFFF);
    writeReg(A_CTRL, 32'hB);
    readCheck("wrap_count", A_COUNT, 32'hFFFF_FFFF);
    readCheck("wrap_nopend", A_CTRL, 32'hB);
    readCheck("wrap_pend", A_CTRL, 32'hF);

    // Asynchronous reset in the middle of an acknowledged access
    req  = 1'b1;
    we   = 1'b0;
    addr = A_CTRL;
    @(posedge clk);
    #2;
    checkOutput("arst_pre_ack",  {31'b0, ack}, 32'd1);
    checkOutput("arst_pre_data", rdata, 32'hF);
    checkOutput("arst_pre_int",  {24'b0, int_sig}, 32'h01);
    rst = 1'b0;
    #1;
    checkOutput("arst_ack",  {31'b0, ack}, 32'd0);
    checkOutput("arst_data", rdata, 32'd0);
    checkOutput("arst_int",  {24'b0, int_sig}, 32'd0);
    req = 1'b0;
    @(negedge clk);
    nextCycle();
    checkOutput("arst_held_ack", {31'b0, ack}, 32'd0);
    rst = 1'b1;
    readCheck("arst_ctrl",  A_CTRL,  32'h0);
    readCheck("arst_count", A_COUNT, 32'h0);
    readCheck("arst_cmp",   A_CMP,   32'hFFFF_FFFF);
    readCheck("arst_presc", A_PRESC, TB_PRESC_RST);
    idle(20);
    readCheck("arst_no_resume", A_COUNT, 32'h0);
    checkOutput("arst_int_idle", {24'b0, int_sig}, 32'd0);

    // Randomized run in lockstep with the model
    doReset();
    modelReset();
    for (int c = 0; c < 600; c++) begin
      checkOutput($sformatf("rnd_ack@%0d", c), {31'b0, ack}, {31'b0, m_ack});
      checkOutput($sformatf("rnd_data@%0d", c), rdata, m_data);
      checkOutput($sformatf("rnd_int@%0d", c), {24'b0, int_sig}, {24'b0, m_int});
      r   = $urandom();
      sel = 2'($urandom_range(0, 3));
      req = ($urandom_range(0, 9) < 4);
      we  = ($urandom_range(0, 9) < 6);
      addr = {r[31:4], sel, r[1:0]};
      case (sel)
        2'd0:    wdata = $urandom();
        2'd1:    wdata = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 6));
        2'd2:    wdata = 32'($urandom_range(0, 6));
        default: wdata = 32'($urandom_range(0, 2));
      endcase
      modelStep(req, we, addr, wdata);
      nextCycle();
    end
    req = 1'b0;
    we  = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/timer_irq.md
Name: timer_irq

Overview:
- Memory-mapped machine timer peripheral, directly upstream of the core-local interruptor.
- Its interrupt output drives the interruptor's `int_flag_i` input.
- Provides a prescaled 32-bit up-counter, a compare register, one-shot or auto-reload mode, and a sticky pending flag with write-1-to-clear.
- Accessed by the core over the simple bus. Raises the timer interrupt code while pending and enabled.

Parameters:
- `PRESC_RST`, default 0: reset value of the prescaler divisor. A tick occurs every PRESC+1 clocks.
- `INT_CODE`, default 8'h01: value driven on `int_sig_o` when the interrupt is asserted.

Ports:
- `clk`  input  1  system clock
- `rst`  input  1  asynchronous active-low reset
- `req_i`  input  1  bus access strobe, one cycle per access
- `we_i`  input  1  1 = write, 0 = read; valid with `req_i`
- `addr_i`  input  32 (`MemAddrBus`)  byte address; only [3:2] decoded
- `data_i`  input  32 (`RegBus`)  write data
- `data_o`  output  32 (`RegBus`)  read data, registered
- `ack_o`  output  1  one-cycle pulse, the cycle after `req_i`
- `int_sig_o`  output  8 (`INT_BUS`)  `INT_CODE` when PEND&IE, else `INT_NONE`

Behaviour:
- Reset (`rst` low, asynchronous, any time):
  - CTRL=0, COUNT=0, CMP=32'hFFFF_FFFF, PRESC=`PRESC_RST`, prescaler counter=0.
  - `data_o`=0, `ack_o`=0, `int_sig_o`=`INT_NONE`.
  - Reset mid-operation discards any in-flight access with no ack.
- Register map (addr[3:2]):
  - 0 = CTRL: bit0 EN, bit1 IE, bit2 PEND (read; write 1 clears), bit3 AR (auto-reload). Bits 31:4 read 0.
  - 1 = COUNT (R/W)
  - 2 = CMP (R/W)
  - 3 = PRESC (R/W)
- Bus:
  - Writes take effect at the clock edge where `req_i`&`we_i` is sampled.
  - Read data is captured at that same edge, so it reflects pre-edge register values; `data_o` and `ack_o` are valid the following cycle.
  - `ack_o` pulses for every access, reads and writes alike.
  - `data_o` holds its last value when there is no read.
- Prescaler:
  - While EN=1, the prescaler counts 0..PRESC and then wraps.
  - A tick occurs in the cycle the prescaler equals PRESC.
  - EN=0 holds the prescaler at 0.
  - A write to CTRL with EN 0→1 zeroes the prescaler.
  - A write to PRESC zeroes the prescaler.
- Counter, on each tick:
  - If COUNT==CMP: set PEND. If AR=1, COUNT←0. If AR=0, COUNT holds and EN←0 (one-shot stop).
  - Otherwise COUNT←COUNT+1, wrapping FFFF_FFFF→0 without setting PEND unless it equals CMP.
- Interrupt output:
  - `int_sig_o` is registered: set to `INT_CODE` the cycle after PEND&IE becomes true, otherwise `INT_NONE`.
  - Clearing IE or PEND drops it one cycle later.
- Simultaneous events:
  - Bus write to COUNT in a tick cycle: the write wins and the increment is lost.
  - Hardware PEND set in the same cycle as a W1C of PEND: the set wins and PEND stays 1.
  - A CTRL write of EN=0 in the same cycle as a one-shot match: PEND still sets.
  - CMP written equal to the current COUNT: the match is evaluated on the next tick, not at the write.
- Unmapped or unaligned addresses: addr[1:0] is ignored. All four word slots are mapped.

Decomposition:
- Shared defines (`bus_defines.v` / `rv32i_defines.v`):
  - `INT_NONE`, `INT_BUS`, `RegBus`, `MemAddrBus`.
  - New `INT_TIMER0`=8'h01.
  - Register offsets `TIMER_CTRL`, `TIMER_COUNT`, `TIMER_CMP`, `TIMER_PRESC`.
  - CTRL bit indices.
- One natural sub-module, `timer_prescaler`:
  - Inputs: clk, rst, en, clr, div.
  - Output: single-cycle tick.
- Register file, counter and interrupt logic stay in `timer_irq`.

Test Plan:
- Reset, then read all four offsets → 0, 0, FFFF_FFFF, `PRESC_RST`. `ack_o` pulses once per read; `int_sig_o`=0.
- PRESC=0, CMP=5, CTRL=0xB (EN, IE, AR) → COUNT runs 0..5. PEND sets at the 6th tick after enable and COUNT returns to 0. `int_sig_o`=8'h01 the next cycle; repeats every 6 clocks while PEND is left set.
- PRESC=3, CMP=2, CTRL=0x3 (one-shot) → a tick every 4 clocks. PEND sets at tick 3, EN reads 0 afterwards, COUNT stays at 2.
- With PEND=1, IE=1: write CTRL=0x7 (W1C of PEND, keeping EN and IE) → PEND=0 and `int_sig_o`=0 one cycle later. Repeat with the W1C timed exactly on a match tick → PEND remains 1.
- Write COUNT=0x100 on a tick cycle → COUNT reads 0x100, not 0x101. Write COUNT=FFFF_FFFF with CMP=0 → next tick gives COUNT=0; the tick after sets PEND.
- Assert `rst` low mid-count with IE/PEND set → all outputs and registers return to reset values immediately (asynchronously), and counting does not resume until EN is rewritten.
